// File: rtl/intr_timer_src.sv
// Interrupt source for the RV32I PC stage: free-running counter with compare, external
// interrupt sync/edge/pending logic and a small register file. INTR_FRC_64BIT_EN selects 64-bit FRC/CMP.
module intr_timer_src #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic        reg_re,
    input  logic [4:2]  reg_adr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_rvalid,
    input  logic        ext_int_in,
    output logic        g_interrupt,
    output logic        g_interrupt_1shot,
    output logic        frc_cntr_val_leq
);

`ifdef INTR_FRC_64BIT_EN
    localparam int unsigned W = 64;
    localparam logic [2:0] AdrFrcHi = 3'd1;
    localparam logic [2:0] AdrCmpHi = 3'd3;
`else
    localparam int unsigned W = 32;
`endif
    localparam logic [2:0] AdrFrcLo = 3'd0;
    localparam logic [2:0] AdrCmpLo = 3'd2;
    localparam logic [2:0] AdrCtrl  = 3'd4;
    localparam logic [2:0] AdrStat  = 3'd5;
    localparam logic [15:0] PresTc  = 16'(PRESCALE - 1);

    logic [15:0]  presc_q, presc_d;
    logic [W-1:0] frc_q, frc_d;
    logic [W-1:0] cmp_q, cmp_d;
    logic         tmr_en_q, ext_en_q;
    logic         leq_q, leq_d;
    logic         sync1_q, sync2_q, ext_prev_q;
    logic         ext_pend_q, ext_pend_d;
    logic         g_int_q, g_int_d;
    logic         oneshot_q, oneshot_d;
    logic [31:0]  rdata_q, rd_mux;
    logic         rvalid_q;
`ifdef INTR_FRC_64BIT_EN
    logic [31:0]  shadow_q;
    logic         wr_frc_hi, wr_cmp_hi;
`endif
    logic         wr_frc_lo, wr_cmp_lo, wr_ctrl, wr_stat, wr_frc;
    logic         tick, ext_edge;

    always_comb begin
        wr_frc_lo = reg_we && (reg_adr == AdrFrcLo);
        wr_cmp_lo = reg_we && (reg_adr == AdrCmpLo);
        wr_ctrl   = reg_we && (reg_adr == AdrCtrl);
        wr_stat   = reg_we && (reg_adr == AdrStat);
`ifdef INTR_FRC_64BIT_EN
        wr_frc_hi = reg_we && (reg_adr == AdrFrcHi);
        wr_cmp_hi = reg_we && (reg_adr == AdrCmpHi);
        wr_frc    = wr_frc_lo || wr_frc_hi;
`else
        wr_frc    = wr_frc_lo;
`endif
        tick = tmr_en_q && (presc_q == PresTc);
    end

    // A bus write to FRC restarts the prescale period and drops a coincident tick.
    always_comb begin
        presc_d = presc_q + 16'd1;
        if (!tmr_en_q || wr_frc || tick) begin
            presc_d = '0;
        end

        frc_d = frc_q;
        if (wr_frc_lo) begin
            frc_d[31:0] = reg_wdata;
        end
`ifdef INTR_FRC_64BIT_EN
        if (wr_frc_hi) begin
            frc_d[63:32] = reg_wdata;
        end
`endif
        if (!wr_frc && tick) begin
            frc_d = frc_q + W'(1);
        end

        cmp_d = cmp_q;
        if (wr_cmp_lo) begin
            cmp_d[31:0] = reg_wdata;
        end
`ifdef INTR_FRC_64BIT_EN
        if (wr_cmp_hi) begin
            cmp_d[63:32] = reg_wdata;
        end
`endif
        leq_d = tmr_en_q && (cmp_q <= frc_q);
    end

    // A freshly detected edge beats a simultaneous W1C.
    always_comb begin
        ext_edge   = sync2_q && !ext_prev_q;
        ext_pend_d = ext_edge || (ext_pend_q && !(wr_stat && reg_wdata[0]));
        g_int_d    = ext_pend_q && ext_en_q;
        oneshot_d  = g_int_d && !g_int_q;
    end

    always_comb begin
        rd_mux = '0;
        case (reg_adr)
            AdrFrcLo: rd_mux = frc_q[31:0];
            AdrCmpLo: rd_mux = cmp_q[31:0];
            AdrCtrl:  rd_mux = {30'd0, ext_en_q, tmr_en_q};
            AdrStat:  rd_mux = {30'd0, leq_q, ext_pend_q};
`ifdef INTR_FRC_64BIT_EN
            AdrFrcHi: rd_mux = shadow_q;
            AdrCmpHi: rd_mux = cmp_q[63:32];
`endif
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            frc_q      <= '0;
            cmp_q      <= '0;
            tmr_en_q   <= 1'b0;
            ext_en_q   <= 1'b0;
            leq_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            ext_prev_q <= 1'b0;
            ext_pend_q <= 1'b0;
            g_int_q    <= 1'b0;
            oneshot_q  <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
`ifdef INTR_FRC_64BIT_EN
            shadow_q   <= '0;
`endif
        end else begin
            presc_q    <= presc_d;
            frc_q      <= frc_d;
            cmp_q      <= cmp_d;
            if (wr_ctrl) begin
                tmr_en_q <= reg_wdata[0];
                ext_en_q <= reg_wdata[1];
            end
            leq_q      <= leq_d;
            sync1_q    <= ext_int_in;
            sync2_q    <= sync1_q;
            ext_prev_q <= sync2_q;
            ext_pend_q <= ext_pend_d;
            g_int_q    <= g_int_d;
            oneshot_q  <= oneshot_d;
            rvalid_q   <= reg_re;
            if (reg_re) begin
                rdata_q <= rd_mux;
            end
`ifdef INTR_FRC_64BIT_EN
            if (reg_re && (reg_adr == AdrFrcLo)) begin
                shadow_q <= frc_q[63:32];
            end
`endif
        end
    end

    assign reg_rdata         = rdata_q;
    assign reg_rvalid        = rvalid_q;
    assign g_interrupt       = g_int_q;
    assign g_interrupt_1shot = oneshot_q;
    assign frc_cntr_val_leq  = leq_q;

endmodule

// File: tb/tb_intr_timer_src.sv
// Self-checking bench for intr_timer_src: randomized scenarios against a cycle-arithmetic
// model of FRC/CMP and interrupt latencies.
module tb_intr_timer_src;

    localparam int unsigned P = 4;
`ifdef INTR_FRC_64BIT_EN
    localparam int W = 64;
`else
    localparam int W = 32;
`endif

    logic        clk = 1'b0;
    logic        rst, reg_we, reg_re, ext_int_in;
    logic [2:0]  reg_adr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_rvalid, g_interrupt, g_interrupt_1shot, frc_cntr_val_leq;

    int n_pass = 0;
    int n_total = 0;
    longint cyc = 0;

    // Model: FRC = base + (cycles since origin)/P while running, else base.
    logic [63:0] m_base, m_cmp;
    longint      m_origin;
    bit          m_run;

    intr_timer_src #(.PRESCALE(P)) u_dut (
        .clk(clk), .rst(rst), .reg_we(reg_we), .reg_re(reg_re), .reg_adr(reg_adr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
        .ext_int_in(ext_int_in), .g_interrupt(g_interrupt),
        .g_interrupt_1shot(g_interrupt_1shot), .frc_cntr_val_leq(frc_cntr_val_leq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] frc_at(input longint t);
        logic [63:0] v;
        v = m_run ? m_base + 64'((t - m_origin) / longint'(P)) : m_base;
        if (W == 32) v[63:32] = '0;
        return v;
    endfunction

    task automatic reset_model();
        m_base = '0; m_cmp = '0; m_origin = 0; m_run = 0;
    endtask

    // Bus tasks start and end on a negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [63:0] prev;
        reg_we = 1'b1; reg_adr = a; reg_wdata = d;
        @(negedge clk);
        reg_we = 1'b0;
        prev = frc_at(cyc - 1);
        case (a)
            3'd0: begin m_base = {prev[63:32], d}; m_origin = cyc; end
            3'd1: if (W == 64) begin m_base = {d, prev[31:0]}; m_origin = cyc; end
            3'd2: m_cmp[31:0] = d;
            3'd3: if (W == 64) m_cmp[63:32] = d;
            3'd4: begin
                if (m_run && !d[0]) begin m_base = frc_at(cyc); m_run = 0; end
                else if (!m_run && d[0]) begin m_origin = cyc; m_run = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v,
                      output longint t);
        reg_re = 1'b1; reg_adr = a; t = cyc;
        @(negedge clk);
        reg_re = 1'b0;
        d = reg_rdata; v = reg_rvalid;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v; longint t;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        n_total++; if (g_interrupt !== 1'b0) $display("FAIL rst_gint got=%b exp=0", g_interrupt); else n_pass++;
        n_total++; if (g_interrupt_1shot !== 1'b0) $display("FAIL rst_1shot got=%b exp=0", g_interrupt_1shot); else n_pass++;
        n_total++; if (frc_cntr_val_leq !== 1'b0) $display("FAIL rst_leq got=%b exp=0", frc_cntr_val_leq); else n_pass++;
        n_total++; if (reg_rvalid !== 1'b0 || reg_rdata !== 32'd0) $display("FAIL rst_bus got=%b/%h exp=0/0", reg_rvalid, reg_rdata); else n_pass++;
        repeat (3) @(negedge clk);
        rd(3'd0, d, v, t);
        n_total++; if (d !== 32'd0 || v !== 1'b1) $display("FAIL rst_frc got=%h/%b exp=0/1", d, v); else n_pass++;
        rd(3'd4, d, v, t);
        n_total++; if (d !== 32'd0) $display("FAIL rst_ctrl got=%h exp=0", d); else n_pass++;
        rd(3'd5, d, v, t);
        n_total++; if (d !== 32'd0) $display("FAIL rst_stat got=%h exp=0", d); else n_pass++;
    endtask

    task automatic test_regs();
        logic [31:0] d, w, e; logic v; longint t;
        for (int i = 0; i < 4; i++) begin
            wr(3'd2, $urandom);
            rd(3'd2, d, v, t);
            n_total++; if (d !== m_cmp[31:0] || v !== 1'b1) $display("FAIL regs_cmplo got=%h exp=%h", d, m_cmp[31:0]); else n_pass++;
            wr(3'd3, $urandom);
            rd(3'd3, d, v, t);
            n_total++; if (d !== m_cmp[63:32]) $display("FAIL regs_cmphi got=%h exp=%h", d, m_cmp[63:32]); else n_pass++;
            wr(3'd0, $urandom);
            rd(3'd0, d, v, t);
            e = frc_at(t) >> 0;
            n_total++; if (d !== e) $display("FAIL regs_frclo got=%h exp=%h", d, e); else n_pass++;
            w = $urandom & 32'hFFFF_FFFE;
            wr(3'd4, w);
            rd(3'd4, d, v, t);
            n_total++; if (d !== (w & 32'h2)) $display("FAIL regs_ctrl got=%h exp=%h", d, w & 32'h2); else n_pass++;
            wr(3'($urandom_range(6, 7)), $urandom);
            rd(3'($urandom_range(6, 7)), d, v, t);
            n_total++; if (d !== 32'd0) $display("FAIL regs_unmapped got=%h exp=0", d); else n_pass++;
        end
        e = d;
        @(negedge clk);
        n_total++; if (reg_rvalid !== 1'b0 || reg_rdata !== e) $display("FAIL regs_hold got=%b/%h exp=0/%h", reg_rvalid, reg_rdata, e); else n_pass++;
        wr(3'd4, 32'd0);
    endtask

    task automatic test_timer_match();
        logic [31:0] c, d; logic v; longint t, t_en, t_hit; bit hit;
        c = 32'($urandom_range(5, 20));
        wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd3, 32'd0); wr(3'd2, c);
        wr(3'd4, 32'd1);
        t_en = cyc; hit = 0; t_hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (frc_cntr_val_leq === 1'b1) begin hit = 1; t_hit = cyc; end
            else @(negedge clk);
        end
        n_total++; if (!hit || t_hit != t_en + longint'(c) * P + 1) $display("FAIL match_rise got=%0d exp=%0d", t_hit - t_en, longint'(c) * P + 1); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (frc_cntr_val_leq !== 1'b1) $display("FAIL match_hold got=%b exp=1", frc_cntr_val_leq); else n_pass++;
        rd(3'd5, d, v, t);
        n_total++; if (d[1] !== 1'b1) $display("FAIL match_stat got=%b exp=1", d[1]); else n_pass++;
        wr(3'd2, 32'd100);
        n_total++; if (frc_cntr_val_leq !== 1'b1) $display("FAIL match_cmpwr_edge got=%b exp=1", frc_cntr_val_leq); else n_pass++;
        @(negedge clk);
        n_total++; if (frc_cntr_val_leq !== 1'b0) $display("FAIL match_cmpwr_drop got=%b exp=0", frc_cntr_val_leq); else n_pass++;
        wr(3'd4, 32'd0);
    endtask

    task automatic test_prescale();
        logic [31:0] d, e; logic v; longint t, t0;
        logic [63:0] x;
        wr(3'd0, 32'd0); wr(3'd1, 32'd0);
        wr(3'd4, 32'd1);
        t0 = cyc;
        repeat (40) @(negedge clk);
        rd(3'd0, d, v, t);
        x = frc_at(t);
        n_total++; if (d !== x[31:0] || t != t0 + 40) $display("FAIL presc_40 got=%0d exp=%0d", d, x[31:0]); else n_pass++;
        wr(3'd4, 32'd0);
        repeat ($urandom_range(3, 20)) @(negedge clk);
        rd(3'd0, d, v, t);
        x = frc_at(t);
        n_total++; if (d !== x[31:0]) $display("FAIL presc_frozen got=%0d exp=%0d", d, x[31:0]); else n_pass++;
        wr(3'd4, 32'd1);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            wr(3'd0, (i == 0) ? 32'hFFFF_FFF8 : $urandom);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            rd(3'd0, d, v, t);
            x = frc_at(t);
            n_total++; if (d !== x[31:0]) $display("FAIL presc_run%0d got=%h exp=%h", i, d, x[31:0]); else n_pass++;
            rd(3'd1, d, v, t);
            n_total++; if (d !== x[63:32]) $display("FAIL presc_hi%0d got=%h exp=%h", i, d, x[63:32]); else n_pass++;
        end
        wr(3'd4, 32'd0);
        e = frc_at(cyc) >> 0;
        repeat (10) @(negedge clk);
        rd(3'd0, d, v, t);
        n_total++; if (d !== e) $display("FAIL presc_stop got=%h exp=%h", d, e); else n_pass++;
    endtask

    task automatic test_atomic();
        logic [31:0] d; logic v; longint t, t0, t_lo;
        logic [63:0] x;
        wr(3'd1, 32'd0); wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd4, 32'd1);
        t0 = cyc;
        while (cyc < t0 + 5) @(negedge clk);
        rd(3'd0, d, v, t_lo);
        x = frc_at(t_lo);
        n_total++; if (d !== x[31:0]) $display("FAIL atomic_lo got=%h exp=%h", d, x[31:0]); else n_pass++;
        while (cyc < t0 + 10) @(negedge clk);
        rd(3'd1, d, v, t);
        n_total++; if (d !== x[63:32]) $display("FAIL atomic_shadow got=%h exp=%h", d, x[63:32]); else n_pass++;
        rd(3'd0, d, v, t_lo);
        x = frc_at(t_lo);
        rd(3'd1, d, v, t);
        n_total++; if (d !== x[63:32]) $display("FAIL atomic_hi2 got=%h exp=%h", d, x[63:32]); else n_pass++;
        wr(3'd4, 32'd0);
    endtask

    task automatic test_ext_int();
        logic [31:0] d; logic v; longint t, c0, first; int pulses, w;
        wr(3'd4, 32'd2);
        for (int r = 0; r < 2; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w = $urandom_range(1, 3);
            ext_int_in = 1'b1; c0 = cyc; first = -1; pulses = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (i == w) ext_int_in = 1'b0;
                if (g_interrupt === 1'b1 && first < 0) first = cyc;
                if (g_interrupt_1shot === 1'b1) pulses++;
            end
            n_total++; if (first != c0 + 4) $display("FAIL ext_lat%0d got=%0d exp=4", r, first - c0); else n_pass++;
            n_total++; if (pulses != 1) $display("FAIL ext_pulses%0d got=%0d exp=1", r, pulses); else n_pass++;
            wr(3'd5, 32'd1);
            @(negedge clk);
            n_total++; if (g_interrupt !== 1'b0) $display("FAIL ext_w1c%0d got=%b exp=0", r, g_interrupt); else n_pass++;
            rd(3'd5, d, v, t);
            n_total++; if (d[0] !== 1'b0) $display("FAIL ext_stat%0d got=%b exp=0", r, d[0]); else n_pass++;
        end
    endtask

    task automatic test_masked();
        logic [31:0] d; logic v; longint t; int pulses, high;
        wr(3'd4, 32'd0);
        ext_int_in = 1'b1; @(negedge clk); ext_int_in = 1'b0;
        high = 0;
        repeat (8) begin @(negedge clk); if (g_interrupt !== 1'b0 || g_interrupt_1shot !== 1'b0) high++; end
        n_total++; if (high != 0) $display("FAIL masked_gint got=%0d exp=0", high); else n_pass++;
        rd(3'd5, d, v, t);
        n_total++; if (d[0] !== 1'b1) $display("FAIL masked_pend got=%b exp=1", d[0]); else n_pass++;
        wr(3'd4, 32'd2);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (g_interrupt_1shot === 1'b1) pulses++;
            @(negedge clk);
        end
        n_total++; if (pulses != 1 || g_interrupt !== 1'b1) $display("FAIL masked_enable got=%0d/%b exp=1/1", pulses, g_interrupt); else n_pass++;
        wr(3'd5, 32'd1);
        repeat (2) @(negedge clk);
        rd(3'd5, d, v, t);
        n_total++; if (d[0] !== 1'b0) $display("FAIL masked_clr got=%b exp=0", d[0]); else n_pass++;
        ext_int_in = 1'b1;
        repeat (2) @(negedge clk);
        wr(3'd5, 32'd1);
        ext_int_in = 1'b0;
        rd(3'd5, d, v, t);
        n_total++; if (d[0] !== 1'b1) $display("FAIL masked_setwins got=%b exp=1", d[0]); else n_pass++;
        n_total++; if (g_interrupt !== 1'b1) $display("FAIL masked_gint2 got=%b exp=1", g_interrupt); else n_pass++;
        wr(3'd5, 32'd1);
        wr(3'd4, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, e;
        logic [2:0]  seq [4];
        logic [31:0] ex [4];
        a = $urandom; b = $urandom;
        wr(3'd2, a);
        e = m_cmp[31:0];
        reg_we = 1'b1; reg_re = 1'b1; reg_adr = 3'd2; reg_wdata = b;
        @(negedge clk);
        reg_we = 1'b0; reg_re = 1'b0;
        m_cmp[31:0] = b;
        n_total++; if (reg_rvalid !== 1'b1 || reg_rdata !== e) $display("FAIL b2b_rw got=%h exp=%h", reg_rdata, e); else n_pass++;
        seq[0] = 3'd2; ex[0] = m_cmp[31:0];
        seq[1] = 3'd4; ex[1] = 32'd0;
        seq[2] = 3'd7; ex[2] = 32'd0;
        seq[3] = 3'd2; ex[3] = m_cmp[31:0];
        reg_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            reg_adr = seq[i];
            @(negedge clk);
            n_total++; if (reg_rvalid !== 1'b1 || reg_rdata !== ex[i]) $display("FAIL b2b_rd%0d got=%b/%h exp=1/%h", i, reg_rvalid, reg_rdata, ex[i]); else n_pass++;
        end
        reg_re = 1'b0;
        @(negedge clk);
        n_total++; if (reg_rvalid !== 1'b0 || reg_rdata !== ex[3]) $display("FAIL b2b_idle got=%b/%h exp=0/%h", reg_rvalid, reg_rdata, ex[3]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v; longint t;
        wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd4, 32'd3);
        ext_int_in = 1'b1; @(negedge clk); ext_int_in = 1'b0;
        repeat (8) @(negedge clk);
        n_total++; if (g_interrupt !== 1'b1 || frc_cntr_val_leq !== 1'b1) $display("FAIL rmid_pre got=%b/%b exp=1/1", g_interrupt, frc_cntr_val_leq); else n_pass++;
        rst = 1'b1; reg_re = 1'b1; reg_adr = 3'd0;
        @(negedge clk);
        rst = 1'b0; reg_re = 1'b0;
        reset_model();
        n_total++; if ({g_interrupt, g_interrupt_1shot, frc_cntr_val_leq} !== 3'b000) $display("FAIL rmid_out got=%b exp=000", {g_interrupt, g_interrupt_1shot, frc_cntr_val_leq}); else n_pass++;
        n_total++; if (reg_rvalid !== 1'b0 || reg_rdata !== 32'd0) $display("FAIL rmid_bus got=%b/%h exp=0/0", reg_rvalid, reg_rdata); else n_pass++;
        @(negedge clk);
        n_total++; if (reg_rvalid !== 1'b0) $display("FAIL rmid_norvalid got=%b exp=0", reg_rvalid); else n_pass++;
        repeat (3) @(negedge clk);
        rd(3'd0, d, v, t);
        n_total++; if (d !== 32'd0) $display("FAIL rmid_frc got=%h exp=0", d); else n_pass++;
        rd(3'd5, d, v, t);
        n_total++; if (d !== 32'd0 || g_interrupt !== 1'b0) $display("FAIL rmid_stat got=%h/%b exp=0/0", d, g_interrupt); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; reg_we = 1'b0; reg_re = 1'b0; reg_adr = '0; reg_wdata = '0;
        ext_int_in = 1'b0;
        reset_model();
        @(negedge clk);
        test_reset();
        test_regs();
        test_timer_match();
        test_prescale();
        test_atomic();
        test_ext_int();
        test_masked();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
